jt51_wrq: RTL and testbench

- Host-side write scheduler in front of jt51_mmr.
- Host writes are queued as address/data pairs in a FIFO; this block drains them one at a time into the mmr's write, a0 and din pins.
- It generates an address strobe followed by a data strobe, then waits for the mmr busy flag to clear before issuing the next pair.
- The host never has to poll busy; back-to-back register programming (voice loads, key-on sequences) never violates the 32-cycle busy window.

---
 rtl/jt51_wrq.sv | 129 ++++++++++++
 tb/tb_jt51_wrq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_wrq.sv
// Host-side write scheduler for jt51_mmr: queues address/data pairs and issues them
// as one-clock address/data strobes, waiting for mmr busy to clear between pairs.
`timescale 1ns/1ps
module jt51_wrq #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned AW             = 4,
  parameter bit          SKIP_SAME_ADDR = 1'b1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          req_valid,
  input  logic [7:0]    req_addr,
  input  logic [7:0]    req_data,
  output logic          req_ready,
  output logic          mmr_write,
  output logic          mmr_a0,
  output logic [7:0]    mmr_din,
  input  logic          mmr_busy,
  output logic [AW:0]   level,
  output logic          idle
);

  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StAddr, StAgap, StData, StDgap, StWaitb} state_e;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop;
  logic [7:0]    head_addr, head_data;

  state_e        state_q;
  logic [7:0]    addr_q, data_q, last_addr_q;
  logic          last_vld_q;
  logic          write_q, a0_q;
  logic [7:0]    din_q;

  // Ready depends only on the registered count, so a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  assign req_ready = (count_q != FullLevel);
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == StIdle) && (count_q != '0);
  assign head_addr = mem[rd_ptr_q][15:8];
  assign head_data = mem[rd_ptr_q][7:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {req_addr, req_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Outputs are set on the transition into each state, so they are valid
  // for exactly the cycle spent in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      data_q      <= '0;
      last_addr_q <= '0;
      last_vld_q  <= 1'b0;
      write_q     <= 1'b0;
      a0_q        <= 1'b0;
      din_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            addr_q  <= head_addr;
            data_q  <= head_data;
            write_q <= 1'b1;
            if (SKIP_SAME_ADDR && last_vld_q && (head_addr == last_addr_q)) begin
              state_q <= StData;
              a0_q    <= 1'b1;
              din_q   <= head_data;
            end else begin
              state_q <= StAddr;
              a0_q    <= 1'b0;
              din_q   <= head_addr;
            end
          end
        end
        StAddr: begin
          write_q     <= 1'b0;
          last_addr_q <= addr_q;
          last_vld_q  <= 1'b1;
          state_q     <= StAgap;
        end
        StAgap: begin
          write_q <= 1'b1;
          a0_q    <= 1'b1;
          din_q   <= data_q;
          state_q <= StData;
        end
        StData: begin
          write_q <= 1'b0;
          state_q <= StDgap;
        end
        // The mmr raises busy a cycle after the strobe, so busy is not sampled here.
        StDgap: state_q <= StWaitb;
        StWaitb: begin
          if (!mmr_busy) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mmr_write = write_q;
  assign mmr_a0    = a0_q;
  assign mmr_din   = din_q;
  assign level     = count_q;
  assign idle      = (state_q == StIdle) && (count_q == '0);

endmodule

// File: tb/tb_jt51_wrq.sv
// Self-checking bench for jt51_wrq: scoreboard of expected mmr strobes plus
// per-scenario timing and occupancy checks, with a simple mmr busy model.
`timescale 1ns/1ps
module tb_jt51_wrq;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam bit          SKIP  = 1'b1;

  logic          rst, clk;
  logic          req_valid;
  logic [7:0]    req_addr, req_data;
  logic          req_ready;
  logic          mmr_write, mmr_a0;
  logic [7:0]    mmr_din;
  logic          mmr_busy;
  logic [AW:0]   level;
  logic          idle;

  jt51_wrq #(.DEPTH(DEPTH), .AW(AW), .SKIP_SAME_ADDR(SKIP)) dut (
    .rst(rst), .clk(clk), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .mmr_write(mmr_write),
    .mmr_a0(mmr_a0), .mmr_din(mmr_din), .mmr_busy(mmr_busy),
    .level(level), .idle(idle)
  );

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];   // {a0, din} of each expected strobe, in order
  int data_times[$];
  int cyc = 0;
  int busy_cnt = 0;
  int busy_len = 3;
  logic busy_hold = 1'b0;
  logic dgap_force = 1'b0;
  logic prev_write = 1'b0;
  logic [7:0] m_last = '0;
  logic m_vld = 1'b0;

  assign mmr_busy = busy_hold || dgap_force || (busy_cnt != 0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor and mmr busy model: busy rises when a data strobe is seen.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy_cnt > 0) busy_cnt--;
      if (mmr_write && !rst) begin
        checks++;
        if (prev_write) begin
          errors++;
          $display("FAIL strobe_width: write high on consecutive cycles at cycle %0d", cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got a0=%0b din=%02h, none expected", mmr_a0, mmr_din);
        end else begin
          e = exp_q.pop_front();
          if ({mmr_a0, mmr_din} !== e)
            begin
              errors++;
              $display("FAIL strobe_value: got a0=%0b din=%02h, expected a0=%0b din=%02h",
                       mmr_a0, mmr_din, e[8], e[7:0]);
            end
        end
        if (mmr_a0) begin
          busy_cnt = busy_len;
          data_times.push_back(cyc);
        end
      end
      prev_write = mmr_write;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    exp_q.delete();
    m_vld = 1'b0;
    busy_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] d);
    bit ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = a;
    req_data = d;
    for (int i = 0; i < 500; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL push_timeout: req_ready stayed 0 for addr=%02h", a);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!(SKIP && m_vld && a == m_last)) exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b1, d});
    m_last = a;
    m_vld = 1'b1;
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && idle) begin done = 1'b1; break; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d idle=%0b, expected pending=0 idle=1",
               name, exp_q.size(), idle);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks += 6;
    if (level !== 0)     begin errors++; $display("FAIL reset_level: got %0d, expected 0", level); end
    if (req_ready !== 1) begin errors++; $display("FAIL reset_ready: got %0b, expected 1", req_ready); end
    if (idle !== 1)      begin errors++; $display("FAIL reset_idle: got %0b, expected 1", idle); end
    if (mmr_write !== 0) begin errors++; $display("FAIL reset_write: got %0b, expected 0", mmr_write); end
    if (mmr_a0 !== 0)    begin errors++; $display("FAIL reset_a0: got %0b, expected 0", mmr_a0); end
    if (mmr_din !== 0)   begin errors++; $display("FAIL reset_din: got %02h, expected 00", mmr_din); end
  endtask

  task automatic test_single();
    busy_len = 3;
    push_pair(8'h20, 8'hC7);
    @(negedge clk);  // after E0
    checks++;
    if (mmr_write !== 0) begin errors++; $display("FAIL single_e0_write: got %0b, expected 0", mmr_write); end
    @(negedge clk);  // after E1
    checks++;
    if ({mmr_write, mmr_a0, mmr_din} !== {1'b1, 1'b0, 8'h20}) begin
      errors++;
      $display("FAIL single_addr_strobe: got w=%0b a0=%0b din=%02h, expected w=1 a0=0 din=20",
               mmr_write, mmr_a0, mmr_din);
    end
    checks++;
    if (level !== 0) begin errors++; $display("FAIL single_pop_level: got %0d, expected 0", level); end
    @(negedge clk);  // after E2
    checks++;
    if (mmr_write !== 0) begin errors++; $display("FAIL single_agap: got write=%0b, expected 0", mmr_write); end
    @(negedge clk);  // after E3
    checks++;
    if ({mmr_write, mmr_a0, mmr_din} !== {1'b1, 1'b1, 8'hC7}) begin
      errors++;
      $display("FAIL single_data_strobe: got w=%0b a0=%0b din=%02h, expected w=1 a0=1 din=C7",
               mmr_write, mmr_a0, mmr_din);
    end
    @(negedge clk);  // after E4
    checks++;
    if (mmr_write !== 0) begin errors++; $display("FAIL single_dgap: got write=%0b, expected 0", mmr_write); end
    wait_drain(50, "single");
  endtask

  task automatic test_skip();
    busy_len = 32;
    data_times.delete();
    push_pair(8'h28, 8'h4A);
    push_pair(8'h28, 8'h4B);
    wait_drain(300, "skip");
    checks++;
    if (data_times.size() != 2) begin
      errors++;
      $display("FAIL skip_count: got %0d data strobes, expected 2", data_times.size());
    end else begin
      checks++;
      if ((data_times[1] - data_times[0]) < busy_len + 1 ||
          (data_times[1] - data_times[0]) > busy_len + 4) begin
        errors++;
        $display("FAIL skip_gap: got %0d cycles between data strobes, expected %0d..%0d",
                 data_times[1] - data_times[0], busy_len + 1, busy_len + 4);
      end
    end
  endtask

  task automatic test_full();
    bit seen = 1'b0;
    busy_len = 2;
    busy_hold = 1'b1;
    for (int i = 0; i < 17; i++) push_pair(8'h40 + 8'(i), 8'(i * 3 + 1));
    repeat (4) @(negedge clk);
    checks += 2;
    if (level !== 16)    begin errors++; $display("FAIL full_level: got %0d, expected 16", level); end
    if (req_ready !== 0) begin errors++; $display("FAIL full_ready: got %0b, expected 0", req_ready); end
    req_valid = 1'b1;
    req_addr = 8'hEE;
    req_data = 8'hEE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    checks++;
    if (level !== 16) begin errors++; $display("FAIL full_refuse: got level %0d, expected 16", level); end
    @(negedge clk);
    busy_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (level != 16) begin seen = 1'b1; break; end
    end
    checks += 2;
    if (!seen || level !== 15) begin
      errors++;
      $display("FAIL full_pop_level: got %0d, expected 15", level);
    end
    if (req_ready !== 1) begin errors++; $display("FAIL full_ready_rise: got %0b, expected 1", req_ready); end
    wait_drain(600, "full");
  endtask

  task automatic test_wrap();
    busy_len = 2;
    busy_hold = 1'b1;
    for (int i = 0; i < 6; i++) push_pair(8'h80 + 8'(i), 8'hA0 + 8'(i));
    repeat (12) @(negedge clk);
    checks++;
    if (level !== 5) begin errors++; $display("FAIL wrap_prefill: got level %0d, expected 5", level); end
    busy_hold = 1'b0;
    @(posedge clk);  // WAITB -> IDLE
    push_pair(8'h90, 8'h11);  // push lands on the pop edge
    checks++;
    if (level !== 5) begin errors++; $display("FAIL wrap_push_pop: got level %0d, expected 5", level); end
    for (int i = 0; i < 33; i++) push_pair(8'(i * 7 % 5), 8'(8'hC0 ^ 8'(i)));
    wait_drain(2000, "wrap");
  endtask

  task automatic test_dgap_busy();
    bit seen = 1'b0;
    busy_len = 0;
    push_pair(8'h55, 8'h66);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mmr_write && mmr_a0) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL dgap_no_data: data strobe not seen, expected one"); end
    @(negedge clk);  // in DGAP
    dgap_force = 1'b1;
    @(negedge clk);  // in WAITB
    dgap_force = 1'b0;
    @(negedge clk);
    checks++;
    if (idle !== 1) begin errors++; $display("FAIL dgap_ignore: got idle=%0b, expected 1", idle); end
    busy_len = 2;
    push_pair(8'h56, 8'h67);
    wait_drain(50, "dgap");
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    busy_len = 2;
    push_pair(8'h33, 8'h55);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (mmr_write && mmr_a0) begin seen = 1'b1; break; end
    end
    rst = 1'b1;
    exp_q.delete();
    m_vld = 1'b0;
    busy_cnt = 0;
    #1;
    checks += 2;
    if (!seen) begin errors++; $display("FAIL rstmid_no_data: data strobe not seen, expected one"); end
    if (mmr_write !== 0) begin errors++; $display("FAIL rstmid_abort: got write=%0b, expected 0", mmr_write); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (level !== 0) begin errors++; $display("FAIL rstmid_level: got %0d, expected 0", level); end
    if (idle !== 1)  begin errors++; $display("FAIL rstmid_idle: got %0b, expected 1", idle); end
    push_pair(8'h33, 8'h77);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mmr_write) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || mmr_a0 !== 0 || mmr_din !== 8'h33) begin
      errors++;
      $display("FAIL rstmid_addr_again: got a0=%0b din=%02h, expected a0=0 din=33", mmr_a0, mmr_din);
    end
    wait_drain(50, "rstmid");
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_skip();
    test_full();
    test_wrap();
    test_dgap_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
